// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch sequencer
package fetch_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef logic [0:15] word_t;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        DECODE,
        AFETCH,
        READY,
        ALARM
    } state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - memory read req/ack bus between fetch sequencer and memory
interface fetch_seq_if;
    import fetch_pkg::*;

    logic  mem_req;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - 8-bit memory wait counter with synchronous restart and expiry flag
module fetch_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_sys,
    input  logic rst_,
    input  logic restart,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    // Saturates so an oversized wait can never wrap back below the limit.
    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt >= 8'(TIMEOUT));

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer: IC strobes, ir/arg fetch, no-memory alarm
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        rst_,
    input  logic        start,
    input  logic        stop,
    input  word_t       ic,
    input  logic        needs_arg,
    input  logic        exec_done,
    input  logic        jmp,
    input  word_t       jaddr,
    input  logic        clr,
    fetch_seq_if.master mem,
    output logic        ic_clr,
    output logic        ic_load,
    output logic        ic_inc,
    output word_t       ic_w,
    output word_t       ir,
    output word_t       arg,
    output logic        ready,
    output logic        alarm
);

    state_t state, state_nx;
    word_t  ir_nx, arg_nx;
    logic   alarm_nx;
    logic   fetching;
    logic   expired;

    assign fetching     = (state == IFETCH) || (state == AFETCH);
    // clr and expiry both withdraw the request in the very cycle they occur.
    assign mem.mem_req  = fetching && !clr && !expired;
    assign mem.mem_addr = mem.mem_req ? ic : '0;
    assign ready        = (state == READY);

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_sys (clk_sys),
        .rst_    (rst_),
        .restart (!fetching),
        .en      (mem.mem_req && !mem.mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            ir    <= '0;
            arg   <= '0;
            alarm <= 1'b0;
        end else begin
            state <= state_nx;
            ir    <= ir_nx;
            arg   <= arg_nx;
            alarm <= alarm_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ir_nx    = ir;
        arg_nx   = arg;
        alarm_nx = alarm;
        ic_clr   = 1'b0;
        ic_load  = 1'b0;
        ic_inc   = 1'b0;
        ic_w     = '0;
        if (clr) begin
            ic_clr   = 1'b1;
            alarm_nx = 1'b0;
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nx = IFETCH;
                IFETCH, AFETCH: begin
                    if (expired) begin
                        alarm_nx = 1'b1;
                        state_nx = ALARM;
                    end else if (mem.mem_ack) begin
                        ic_inc = 1'b1;
                        if (state == IFETCH) begin
                            ir_nx    = mem.mem_data;
                            state_nx = DECODE;
                        end else begin
                            arg_nx   = mem.mem_data;
                            state_nx = READY;
                        end
                    end
                end
                DECODE: begin
                    if (needs_arg) begin
                        state_nx = AFETCH;
                    end else begin
                        arg_nx   = '0;
                        state_nx = READY;
                    end
                end
                READY: begin
                    if (exec_done) begin
                        if (jmp) begin
                            ic_load = 1'b1;
                            ic_w    = jaddr;
                        end
                        state_nx = stop ? IDLE : IFETCH;
                    end
                end
                ALARM: begin
                    if (start) begin
                        alarm_nx = 1'b0;
                        state_nx = IFETCH;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed self-checking bench for fetch_seq
module tb_fetch_seq;
    import fetch_pkg::*;

    logic  clk_sys = 1'b0;
    logic  rst_;
    logic  start, stop, needs_arg, exec_done, jmp, clr;
    word_t ic, jaddr, ic_w, ir, arg, ic_set_val;
    logic  ic_clr, ic_load, ic_inc, ready, alarm, ic_set;
    int    total = 0;
    int    bad = 0;
    int    inc_cnt = 0;
    int    load_cnt = 0;
    int    multi_cnt = 0;
    int    snap;

    always #5 clk_sys = ~clk_sys;

    fetch_seq_if mem ();

    fetch_seq #(.TIMEOUT(4)) dut (
        .clk_sys   (clk_sys),
        .rst_      (rst_),
        .start     (start),
        .stop      (stop),
        .ic        (ic),
        .needs_arg (needs_arg),
        .exec_done (exec_done),
        .jmp       (jmp),
        .jaddr     (jaddr),
        .clr       (clr),
        .mem       (mem.master),
        .ic_clr    (ic_clr),
        .ic_load   (ic_load),
        .ic_inc    (ic_inc),
        .ic_w      (ic_w),
        .ir        (ir),
        .arg       (arg),
        .ready     (ready),
        .alarm     (alarm)
    );

    // Model of the IC register plus strobe bookkeeping.
    always @(posedge clk_sys) begin
        if (ic_clr)       ic <= 16'h0000;
        else if (ic_load) ic <= ic_w;
        else if (ic_inc)  ic <= ic + 16'h0001;
        else if (ic_set)  ic <= ic_set_val;
        if (ic_inc)  inc_cnt  <= inc_cnt + 1;
        if (ic_load) load_cnt <= load_cnt + 1;
        if ($countones({ic_clr, ic_load, ic_inc}) > 1) multi_cnt <= multi_cnt + 1;
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_ic(input word_t v);
        ic_set = 1'b1;
        ic_set_val = v;
        step();
        ic_set = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem.mem_req); end
        total++; if (mem.mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", mem.mem_addr); end
        total++; if ({ic_clr, ic_load, ic_inc} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%b exp=000", {ic_clr, ic_load, ic_inc}); end
        total++; if (ir !== 16'h0000 || arg !== 16'h0000 || ic_w !== 16'h0000) begin bad++; $display("FAIL rst_regs got=%h/%h/%h exp=0", ir, arg, ic_w); end
        total++; if (ready !== 1'b0 || alarm !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", ready, alarm); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, IDLE); end
        step();
        rst_ = 1'b1;
    endtask

    task automatic test_one_word();
        set_ic(16'h0100);
        snap = inc_cnt;
        needs_arg = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 16'h0100) begin bad++; $display("FAIL w1_req got=%b/%h exp=1/0100", mem.mem_req, mem.mem_addr); end
        step();
        step();
        total++; if (mem.mem_req !== 1'b1) begin bad++; $display("FAIL w1_req_hold got=%b exp=1", mem.mem_req); end
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'h1234;
        #1;
        total++; if (ic_inc !== 1'b1) begin bad++; $display("FAIL w1_inc got=%b exp=1", ic_inc); end
        step();
        mem.mem_ack = 1'b0;
        total++; if (mem.mem_req !== 1'b0 || ir !== 16'h1234) begin bad++; $display("FAIL w1_decode got=%b/%h exp=0/1234", mem.mem_req, ir); end
        step();
        total++; if (ready !== 1'b1 || arg !== 16'h0000) begin bad++; $display("FAIL w1_ready got=%b/%h exp=1/0000", ready, arg); end
        total++; if (inc_cnt - snap !== 1 || ic !== 16'h0101) begin bad++; $display("FAIL w1_ic got=%0d/%h exp=1/0101", inc_cnt - snap, ic); end
        exec_done = 1'b1;
        stop = 1'b1;
        step();
        exec_done = 1'b0;
        stop = 1'b0;
        total++; if (ready !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL w1_stop got=%b/%0d exp=0/%0d", ready, dut.state, IDLE); end
    endtask

    task automatic test_two_word();
        set_ic(16'h0100);
        snap = inc_cnt;
        needs_arg = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'h8000;
        #1;
        total++; if (mem.mem_addr !== 16'h0100) begin bad++; $display("FAIL w2_addr0 got=%h exp=0100", mem.mem_addr); end
        step();
        mem.mem_ack = 1'b0;
        total++; if (ir !== 16'h8000) begin bad++; $display("FAIL w2_ir got=%h exp=8000", ir); end
        step();
        total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 16'h0101) begin bad++; $display("FAIL w2_addr1 got=%b/%h exp=1/0101", mem.mem_req, mem.mem_addr); end
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'hBEEF;
        step();
        mem.mem_ack = 1'b0;
        total++; if (ready !== 1'b1 || arg !== 16'hBEEF) begin bad++; $display("FAIL w2_ready got=%b/%h exp=1/beef", ready, arg); end
        total++; if (inc_cnt - snap !== 2 || ic !== 16'h0102) begin bad++; $display("FAIL w2_ic got=%0d/%h exp=2/0102", inc_cnt - snap, ic); end
    endtask

    task automatic test_jump();
        snap = load_cnt;
        exec_done = 1'b1;
        jmp = 1'b1;
        jaddr = 16'h2000;
        #1;
        total++; if (ic_load !== 1'b1 || ic_w !== 16'h2000 || ic_inc !== 1'b0) begin bad++; $display("FAIL jmp_load got=%b/%h/%b exp=1/2000/0", ic_load, ic_w, ic_inc); end
        step();
        exec_done = 1'b0;
        jmp = 1'b0;
        total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 16'h2000 || ready !== 1'b0) begin bad++; $display("FAIL jmp_fetch got=%b/%h/%b exp=1/2000/0", mem.mem_req, mem.mem_addr, ready); end
        needs_arg = 1'b0;
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'h0001;
        step();
        mem.mem_ack = 1'b0;
        step();
        exec_done = 1'b1;
        jmp = 1'b1;
        stop = 1'b1;
        jaddr = 16'h3000;
        step();
        exec_done = 1'b0;
        jmp = 1'b0;
        stop = 1'b0;
        total++; if (mem.mem_req !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL jmp_stop got=%b/%0d exp=0/%0d", mem.mem_req, dut.state, IDLE); end
        total++; if (load_cnt - snap !== 2 || ic !== 16'h3000) begin bad++; $display("FAIL jmp_ic got=%0d/%h exp=2/3000", load_cnt - snap, ic); end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        total++; if (mem.mem_req !== 1'b1 || alarm !== 1'b0) begin bad++; $display("FAIL to_wait got=%b/%b exp=1/0", mem.mem_req, alarm); end
        step();
        total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL to_drop got=%b exp=0", mem.mem_req); end
        step();
        total++; if (alarm !== 1'b1 || dut.state !== ALARM || mem.mem_req !== 1'b0) begin bad++; $display("FAIL to_alarm got=%b/%0d/%b exp=1/%0d/0", alarm, dut.state, mem.mem_req, ALARM); end
        step();
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", alarm); end
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (alarm !== 1'b0 || mem.mem_req !== 1'b1 || mem.mem_addr !== 16'h3000) begin bad++; $display("FAIL to_restart got=%b/%b/%h exp=0/1/3000", alarm, mem.mem_req, mem.mem_addr); end
        clr = 1'b1;
        #1;
        total++; if (ic_clr !== 1'b1 || mem.mem_req !== 1'b0) begin bad++; $display("FAIL to_clr got=%b/%b exp=1/0", ic_clr, mem.mem_req); end
        step();
        clr = 1'b0;
        total++; if (dut.state !== IDLE || ic !== 16'h0000) begin bad++; $display("FAIL to_idle got=%0d/%h exp=%0d/0000", dut.state, ic, IDLE); end
    endtask

    task automatic test_clr_ack();
        set_ic(16'h0400);
        needs_arg = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'h8000;
        step();
        mem.mem_ack = 1'b0;
        step();
        total++; if (mem.mem_addr !== 16'h0401) begin bad++; $display("FAIL ca_addr got=%h exp=0401", mem.mem_addr); end
        snap = inc_cnt;
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'hDEAD;
        clr = 1'b1;
        #1;
        total++; if (ic_clr !== 1'b1 || ic_inc !== 1'b0 || mem.mem_req !== 1'b0) begin bad++; $display("FAIL ca_strobe got=%b/%b/%b exp=1/0/0", ic_clr, ic_inc, mem.mem_req); end
        step();
        mem.mem_ack = 1'b0;
        clr = 1'b0;
        total++; if (arg !== 16'h0000 || ir !== 16'h8000) begin bad++; $display("FAIL ca_regs got=%h/%h exp=0000/8000", arg, ir); end
        total++; if (dut.state !== IDLE || ready !== 1'b0 || ic !== 16'h0000 || inc_cnt != snap) begin bad++; $display("FAIL ca_idle got=%0d/%b/%h/%0d exp=%0d/0/0000/0", dut.state, ready, ic, inc_cnt - snap, IDLE); end
    endtask

    task automatic test_wrap();
        set_ic(16'hFFFF);
        needs_arg = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'h8001;
        #1;
        total++; if (mem.mem_addr !== 16'hFFFF) begin bad++; $display("FAIL wr_addr0 got=%h exp=ffff", mem.mem_addr); end
        step();
        mem.mem_ack = 1'b0;
        step();
        total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 16'h0000) begin bad++; $display("FAIL wr_addr1 got=%b/%h exp=1/0000", mem.mem_req, mem.mem_addr); end
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'h5555;
        step();
        mem.mem_ack = 1'b0;
        total++; if (ready !== 1'b1 || arg !== 16'h5555 || ir !== 16'h8001) begin bad++; $display("FAIL wr_ready got=%b/%h/%h exp=1/5555/8001", ready, arg, ir); end
    endtask

    task automatic test_async_reset();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        total++; if (dut.state !== IFETCH || mem.mem_req !== 1'b1) begin bad++; $display("FAIL ar_fetch got=%0d/%b exp=%0d/1", dut.state, mem.mem_req, IFETCH); end
        #2;
        rst_ = 1'b0;
        #1;
        total++; if (mem.mem_req !== 1'b0 || dut.state !== IDLE || ir !== 16'h0000) begin bad++; $display("FAIL ar_drop got=%b/%0d/%h exp=0/%0d/0000", mem.mem_req, dut.state, ir, IDLE); end
        step();
        rst_ = 1'b1;
        mem.mem_ack = 1'b1;
        mem.mem_data = 16'h7777;
        step();
        mem.mem_ack = 1'b0;
        total++; if (ir !== 16'h0000 || dut.state !== IDLE || ic_inc !== 1'b0) begin bad++; $display("FAIL ar_late got=%h/%0d/%b exp=0000/%0d/0", ir, dut.state, ic_inc, IDLE); end
    endtask

    initial begin
        rst_ = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        needs_arg = 1'b0;
        exec_done = 1'b0;
        jmp = 1'b0;
        clr = 1'b0;
        jaddr = 16'h0000;
        ic_set = 1'b0;
        ic_set_val = 16'h0000;
        mem.mem_ack = 1'b0;
        mem.mem_data = 16'h0000;
        test_reset();
        test_one_word();
        test_two_word();
        test_jump();
        test_timeout();
        test_clr_ack();
        test_wrap();
        test_async_reset();
        total++; if (multi_cnt != 0) begin bad++; $display("FAIL strobe_excl got=%0d exp=0", multi_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch sequencer for the instruction counter (IC). It issues IC clear, load and increment strobes, fetches the instruction word and the optional argument word from memory over a req/ack handshake, and presents both to the execution control. It also detects a missing memory response and raises a no-memory alarm. It sits between the IC register, the memory bus interface and the execution control unit.

## Interface
Parameters:
- TIMEOUT, 255: number of cycles a memory request may stay unacknowledged before the alarm is raised. Range 1..255; the counter is 8 bits.

Ports (bit 0 is the MSB, all buses [0:15]):
- clk_sys  in  1  system clock, rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- start  in  1  begin fetching at the current IC. Sampled only in IDLE or ALARM.
- stop  in  1  when high at exec_done, return to IDLE instead of fetching.
- ic  in  16  current IC value.
- needs_arg  in  1  decoder output derived from ir. Valid in DECODE.
- exec_done  in  1  execution of the current instruction has finished. Sampled in READY.
- jmp  in  1  qualifies exec_done: load IC from jaddr.
- jaddr  in  16  jump target.
- clr  in  1  clear IC and abort the current sequence. Honoured in any state.
- mem_req  out  1  memory read request.
- mem_addr  out  16  read address.
- mem_ack  in  1  single-cycle acknowledge, one per request. mem_data is valid in the same cycle.
- mem_data  in  16  read data.
- ic_clr  out  1  one-cycle strobe: IC := 0.
- ic_load  out  1  one-cycle strobe: IC := ic_w.
- ic_inc  out  1  one-cycle strobe: IC := IC+1.
- ic_w  out  16  load value.
- ir  out  16  instruction word.
- arg  out  16  argument word (0 when the instruction takes no argument).
- ready  out  1  ir and arg are valid.
- alarm  out  1  no-memory alarm. Sticky.

## Operation
- States: IDLE, IFETCH, DECODE, AFETCH, READY, ALARM.
- IDLE: on start, go to IFETCH.
- IFETCH and AFETCH:
  - mem_req=1 and mem_addr=ic.
  - On mem_ack, latch mem_data (into ir in IFETCH, into arg in AFETCH) and pulse ic_inc.
  - After the ack, IFETCH goes to DECODE and AFETCH goes to READY.
- DECODE: if needs_arg, go to AFETCH; otherwise clear arg and go to READY.
- READY: ready=1. On exec_done:
  - If jmp, pulse ic_load with ic_w=jaddr.
  - Then go to IDLE if stop, else to IFETCH.
- Timeout:
  - An 8-bit wait counter resets on entry to IFETCH or AFETCH and increments each cycle mem_req is high without mem_ack.
  - When the counter reaches TIMEOUT: set alarm, drop mem_req, go to ALARM.
- ALARM: stays until clr or start. start clears alarm and goes to IFETCH. clr clears alarm and goes to IDLE.
- Priority within a cycle:
  - clr is highest. It pulses ic_clr, drops mem_req and goes to IDLE. A mem_ack arriving in that same cycle is ignored: no ir/arg latch, no ic_inc.
  - jmp is honoured only when exec_done is high; ic_load and ic_inc are never asserted together.
- IC strobes are mutually exclusive. At most one of ic_clr, ic_load or ic_inc is asserted per cycle.
- IC wrap: 0xFFFF+1 = 0x0000, performed by the IC. The sequencer takes no special action.
- Reset values: state IDLE; all outputs 0 (mem_req, mem_addr, ic_clr, ic_load, ic_inc, ic_w, ir, arg, ready, alarm); wait counter 0.

## Timing
- Strobes are asserted in the cycle the event is sampled. IC updates at that clk_sys edge.
- The next state observes the new ic one cycle later, so AFETCH addresses IC+1 with no extra wait.
- Minimum latency from start to ready:
  - 1-word instruction, ack in the first cycle: 3 cycles (IFETCH, DECODE, READY).
  - 2-word instruction: 4 cycles.
- mem_req stays high from state entry until the ack cycle inclusive. It falls the cycle after the ack.
- ready falls in the cycle after exec_done is sampled.
- From exec_done with jmp to mem_req at jaddr: 1 cycle.
- rst_ mid-request: mem_req drops immediately (asynchronous). A late ack after reset is ignored in IDLE.

## Structure
- Shared package fetch_pkg holds:
  - state enum (IDLE, IFETCH, DECODE, AFETCH, READY, ALARM);
  - TIMEOUT default;
  - 16-bit word typedef.
- One sub-module, fetch_timer: the 8-bit wait counter with synchronous restart and an expiry flag.
- Everything else is a single FSM plus the ir/arg registers.

## Test plan
- Reset and start with ic=0x0100, needs_arg=0, ack after 2 cycles with data 0x1234 → mem_addr=0x0100, ir=0x1234, arg=0, one ic_inc, ready=1.
- 2-word instruction, ic=0x0100, data 0x8000 then 0xBEEF → second mem_addr=0x0101, ir=0x8000, arg=0xBEEF, two ic_inc pulses.
- In READY, exec_done+jmp with jaddr=0x2000 → one ic_load with ic_w=0x2000, then mem_req at 0x2000 next cycle. Repeat with stop=1 → IDLE, no mem_req.
- TIMEOUT=4, no ack → alarm=1 after 4 wait cycles, mem_req=0, state ALARM. Then start → alarm=0 and refetch.
- clr in the same cycle as mem_ack during AFETCH → ic_clr only, no ic_inc, arg unchanged, state IDLE, ready=0.
- ic=0xFFFF, 2-word fetch → AFETCH addresses 0x0000.
